// File: rtl/pc_adr_unit.sv
// pc_adr_unit -- program counter and data-address assembly unit.
//
// Purpose:
//   Holds the 8-bit program counter (increment, conditional jump) and
//   assembles an 18-bit data-memory address from three byte writes taken
//   off the instruction-memory data register. The assembled address is
//   transferred to DAR on request.
//   All registers update on the falling edge of clock, so they line up with
//   the controller that drives the inputs. rst is asynchronous, active-high.
//
// Optional feature (macro RET_STACK_EN):
//   When defined, a 4-entry 8-bit return stack is built and the jmp_call and
//   jmp_ret codes become active. When undefined, both codes are treated as
//   unrecognised jump conditions and stk_err is tied to 0.
//
// Ports:
//   clock      in   1   system clock, registers sample on the falling edge
//   rst        in   1   asynchronous active-high reset
//   MIDR       in   8   instruction-memory data (jump target / address byte)
//   PCI        in   1   PC increment strobe
//   PRM        in   2   parameter mode (prm_jmp, prm_adr acted on)
//   PRM_param  in   4   jump condition code
//   OPR        in   3   operation select (opr_pc acted on)
//   ADR        in   4   address-assembly code
//   z_flag     in   1   accumulator-zero flag
//   PC         out  8   instruction address
//   DAR        out  18  data-memory address
//   adr_ok     out  1   all three address parts written since last transfer
//   stk_err    out  1   sticky return-stack overflow/underflow
//
// Code encodings:
//   PRM:       prm_jmp=1, prm_adr=2 (0 and 3 are no-ops here)
//   OPR:       opr_pc=1
//   PRM_param: jmp_jump=1, jmp_jz=2, jmp_jnz=3, jmp_call=4, jmp_ret=5
//   ADR:       adr_none=0, adr_first2=1, adr_mid8=2, adr_last8=3

module pc_adr_unit (
  input  logic        clock,
  input  logic        rst,
  input  logic [7:0]  MIDR,
  input  logic        PCI,
  input  logic [1:0]  PRM,
  input  logic [3:0]  PRM_param,
  input  logic [2:0]  OPR,
  input  logic [3:0]  ADR,
  input  logic        z_flag,
  output logic [7:0]  PC,
  output logic [17:0] DAR,
  output logic        adr_ok,
  output logic        stk_err
);

  localparam logic [1:0] PRM_JMP    = 2'd1;
  localparam logic [1:0] PRM_ADR    = 2'd2;
  localparam logic [2:0] OPR_PC     = 3'd1;
  localparam logic [3:0] JMP_JUMP   = 4'd1;
  localparam logic [3:0] JMP_JZ     = 4'd2;
  localparam logic [3:0] JMP_JNZ    = 4'd3;
  localparam logic [3:0] ADR_FIRST2 = 4'd1;
  localparam logic [3:0] ADR_MID8   = 4'd2;
  localparam logic [3:0] ADR_LAST8  = 4'd3;

  logic [7:0]  pc_q, pc_d;
  logic [17:0] ar_q, ar_d;
  logic [17:0] dar_q, dar_d;
  logic [2:0]  mask_q, mask_d;

  logic        jmp_req;
  logic        cond_taken;
  logic [7:0]  pc_inc;

  assign jmp_req = (PRM == PRM_JMP) && (OPR == OPR_PC);
  assign pc_inc  = pc_q + 8'd1;

  assign cond_taken = jmp_req &&
                      ((PRM_param == JMP_JUMP) ||
                       ((PRM_param == JMP_JZ)  &&  z_flag) ||
                       ((PRM_param == JMP_JNZ) && !z_flag));

`ifdef RET_STACK_EN
  localparam logic [3:0] JMP_CALL = 4'd4;
  localparam logic [3:0] JMP_RET  = 4'd5;

  // sp counts occupied entries (0..4); entry sp-1 is the top of stack.
  logic [7:0] stk_q [4];
  logic [7:0] stk_d [4];
  logic [2:0] sp_q, sp_d;
  logic       err_q, err_d;
  logic [2:0] sp_dec;

  assign sp_dec = sp_q - 3'd1;
`endif

  // Program counter and return stack.
  always_comb begin
    pc_d = pc_q;
    if (PCI) begin
      pc_d = pc_inc;
    end
    // A taken jump overrides the increment in the same clock.
    if (cond_taken) begin
      pc_d = MIDR;
    end
`ifdef RET_STACK_EN
    stk_d = stk_q;
    sp_d  = sp_q;
    err_d = err_q;
    if (jmp_req && (PRM_param == JMP_CALL)) begin
      // A push into a full stack is dropped but the call still jumps.
      if (sp_q == 3'd4) begin
        err_d = 1'b1;
      end else begin
        stk_d[sp_q[1:0]] = pc_inc;
        sp_d             = sp_q + 3'd1;
      end
      pc_d = MIDR;
    end
    if (jmp_req && (PRM_param == JMP_RET)) begin
      // A pop from an empty stack flags and freezes PC, increment included.
      if (sp_q == 3'd0) begin
        err_d = 1'b1;
        pc_d  = pc_q;
      end else begin
        pc_d = stk_q[sp_dec[1:0]];
        sp_d = sp_dec;
      end
    end
`endif
  end

  // Address assembly and transfer.
  always_comb begin
    ar_d   = ar_q;
    mask_d = mask_q;
    dar_d  = dar_q;
    case (ADR)
      ADR_FIRST2: begin
        ar_d[17:16] = MIDR[1:0];
        mask_d[0]   = 1'b1;
      end
      ADR_MID8: begin
        ar_d[15:8] = MIDR;
        mask_d[1]  = 1'b1;
      end
      ADR_LAST8: begin
        ar_d[7:0] = MIDR;
        mask_d[2] = 1'b1;
      end
      default: ;
    endcase
    // Transfer uses the freshly written byte (write-through) and always
    // clears the mask, even if parts were missing.
    if (PRM == PRM_ADR) begin
      dar_d  = ar_d;
      mask_d = 3'b000;
    end
  end

  always_ff @(negedge clock or posedge rst) begin
    if (rst) begin
      pc_q   <= 8'h00;
      ar_q   <= 18'h0;
      dar_q  <= 18'h0;
      mask_q <= 3'b000;
    end else begin
      pc_q   <= pc_d;
      ar_q   <= ar_d;
      dar_q  <= dar_d;
      mask_q <= mask_d;
    end
  end

`ifdef RET_STACK_EN
  always_ff @(negedge clock or posedge rst) begin
    if (rst) begin
      sp_q  <= 3'd0;
      err_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        stk_q[i] <= 8'h00;
      end
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
      stk_q <= stk_d;
    end
  end

  assign stk_err = err_q;
`else
  assign stk_err = 1'b0;
`endif

  assign PC     = pc_q;
  assign DAR    = dar_q;
  assign adr_ok = (mask_q == 3'b111);

endmodule

// File: tb/tb_pc_adr_unit.sv
// tb_pc_adr_unit -- self-checking bench for pc_adr_unit.
// Table of directed vectors, hand-written multi-cycle sequences (wrap, async
// reset, optional return stack) and randomized stimulus checked against a
// behavioural model. Inputs change one time unit after the falling edge and
// outputs are sampled one time unit after the falling edge.

module tb_pc_adr_unit;

  localparam logic [1:0] P_NONE  = 2'd0;
  localparam logic [1:0] P_JMP   = 2'd1;
  localparam logic [1:0] P_ADR   = 2'd2;
  localparam logic [2:0] O_NONE  = 3'd0;
  localparam logic [2:0] O_PC    = 3'd1;
  localparam logic [3:0] J_NONE  = 4'd0;
  localparam logic [3:0] J_JUMP  = 4'd1;
  localparam logic [3:0] J_JZ    = 4'd2;
  localparam logic [3:0] J_JNZ   = 4'd3;
  localparam logic [3:0] J_CALL  = 4'd4;
  localparam logic [3:0] J_RET   = 4'd5;
  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_F2    = 4'd1;
  localparam logic [3:0] A_M8    = 4'd2;
  localparam logic [3:0] A_L8    = 4'd3;

  logic        clock;
  logic        rst;
  logic [7:0]  MIDR;
  logic        PCI;
  logic [1:0]  PRM;
  logic [3:0]  PRM_param;
  logic [2:0]  OPR;
  logic [3:0]  ADR;
  logic        z_flag;
  logic [7:0]  PC;
  logic [17:0] DAR;
  logic        adr_ok;
  logic        stk_err;

  int checks;
  int errors;

  // Behavioural model state.
  int m_pc;
  int m_ar;
  int m_dar;
  bit m_part [3];
  bit m_err;
  int m_stack [$];

  pc_adr_unit dut (
    .clock     (clock),
    .rst       (rst),
    .MIDR      (MIDR),
    .PCI       (PCI),
    .PRM       (PRM),
    .PRM_param (PRM_param),
    .OPR       (OPR),
    .ADR       (ADR),
    .z_flag    (z_flag),
    .PC        (PC),
    .DAR       (DAR),
    .adr_ok    (adr_ok),
    .stk_err   (stk_err)
  );

  initial begin
    clock = 1'b1;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        pci;
    logic [1:0]  prm;
    logic [3:0]  code;
    logic [2:0]  opr;
    logic [3:0]  adr;
    logic [7:0]  midr;
    logic        z;
    logic [7:0]  exp_pc;
    logic [17:0] exp_dar;
    logic        exp_ok;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_ar  = 0;
    m_dar = 0;
    m_err = 0;
    for (int i = 0; i < 3; i++) m_part[i] = 0;
    m_stack.delete();
  endtask

  function automatic bit model_ok();
    return m_part[0] && m_part[1] && m_part[2];
  endfunction

  // Applies the architectural rules to the inputs present at an edge.
  task automatic model_step();
    bit req;
    int next_pc;
    req = (PRM == P_JMP) && (OPR == O_PC);
    next_pc = PCI ? (m_pc + 1) % 256 : m_pc;
    if (req && (PRM_param == J_JUMP || (PRM_param == J_JZ && z_flag) ||
                (PRM_param == J_JNZ && !z_flag)))
      next_pc = MIDR;
`ifdef RET_STACK_EN
    if (req && PRM_param == J_CALL) begin
      if (m_stack.size() == 4) m_err = 1;
      else m_stack.push_back((m_pc + 1) % 256);
      next_pc = MIDR;
    end
    if (req && PRM_param == J_RET) begin
      if (m_stack.size() == 0) begin
        m_err = 1;
        next_pc = m_pc;
      end else begin
        next_pc = m_stack.pop_back();
      end
    end
`endif
    m_pc = next_pc;
    if (ADR == A_F2) begin m_ar = (m_ar % 65536) + (MIDR % 4) * 65536; m_part[0] = 1; end
    if (ADR == A_M8) begin m_ar = (m_ar / 65536) * 65536 + MIDR * 256 + (m_ar % 256); m_part[1] = 1; end
    if (ADR == A_L8) begin m_ar = (m_ar / 256) * 256 + MIDR; m_part[2] = 1; end
    if (PRM == P_ADR) begin
      m_dar = m_ar;
      for (int i = 0; i < 3; i++) m_part[i] = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_pc"},  {24'h0, PC},  m_pc);
    check({tag, "_dar"}, {14'h0, DAR}, m_dar);
    check({tag, "_ok"},  {31'h0, adr_ok}, {31'h0, model_ok()});
    check({tag, "_err"}, {31'h0, stk_err}, {31'h0, m_err});
  endtask

  // One clock transaction: drive, clock, update model, sample, compare.
  task automatic step(input logic pci, input logic [1:0] prm, input logic [3:0] code,
                      input logic [2:0] opr, input logic [3:0] adr, input logic [7:0] midr,
                      input logic z, input string tag);
    PCI = pci; PRM = prm; PRM_param = code; OPR = opr; ADR = adr; MIDR = midr; z_flag = z;
    @(negedge clock);
    model_step();
    #1;
    $display("%s pci=%0b prm=%0d code=%0d opr=%0d adr=%0d midr=%02h z=%0b -> pc=%02h dar=%05h ok=%0b err=%0b",
             tag, pci, prm, code, opr, adr, midr, z, PC, DAR, adr_ok, stk_err);
    compare_model(tag);
  endtask

  task automatic idle_inputs();
    PCI = 0; PRM = P_NONE; PRM_param = J_NONE; OPR = O_NONE; ADR = A_NONE; MIDR = 8'h00; z_flag = 0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    check({tag, "_rst_pc"},  {24'h0, PC}, 32'h0);
    check({tag, "_rst_dar"}, {14'h0, DAR}, 32'h0);
    check({tag, "_rst_ok"},  {31'h0, adr_ok}, 32'h0);
    check({tag, "_rst_err"}, {31'h0, stk_err}, 32'h0);
    model_reset();
    @(negedge clock);
    #1;
    rst = 1'b0;
    $display("%s reset released pc=%02h dar=%05h", tag, PC, DAR);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    idle_inputs();
    model_reset();
    #2;

    //              pci prm    code    opr     adr    midr   z  pc     dar        ok
    vecs[0]  = '{1'b1, P_NONE, J_NONE, O_NONE, A_NONE, 8'h00, 0, 8'h01, 18'h00000, 0};
    vecs[1]  = '{1'b1, P_NONE, J_NONE, O_NONE, A_NONE, 8'h00, 0, 8'h02, 18'h00000, 0};
    vecs[2]  = '{1'b1, P_NONE, J_NONE, O_NONE, A_NONE, 8'h00, 0, 8'h03, 18'h00000, 0};
    vecs[3]  = '{1'b1, P_JMP,  J_JUMP, O_PC,   A_NONE, 8'h40, 0, 8'h40, 18'h00000, 0};
    vecs[4]  = '{1'b0, P_JMP,  J_JZ,   O_PC,   A_NONE, 8'h22, 0, 8'h40, 18'h00000, 0};
    vecs[5]  = '{1'b0, P_JMP,  J_JZ,   O_PC,   A_NONE, 8'h22, 1, 8'h22, 18'h00000, 0};
    vecs[6]  = '{1'b1, P_JMP,  J_JNZ,  O_PC,   A_NONE, 8'h50, 1, 8'h23, 18'h00000, 0};
    vecs[7]  = '{1'b0, P_NONE, J_NONE, O_NONE, A_F2,   8'h03, 0, 8'h23, 18'h00000, 0};
    vecs[8]  = '{1'b1, P_NONE, J_NONE, O_NONE, A_M8,   8'hAB, 0, 8'h24, 18'h00000, 0};
    vecs[9]  = '{1'b0, P_NONE, J_NONE, O_NONE, A_L8,   8'hCD, 0, 8'h24, 18'h00000, 1};
    vecs[10] = '{1'b0, P_ADR,  J_NONE, O_NONE, A_NONE, 8'h00, 0, 8'h24, 18'h3ABCD, 0};
    vecs[11] = '{1'b0, P_JMP,  J_JUMP, O_NONE, A_NONE, 8'h99, 0, 8'h24, 18'h3ABCD, 0};
    vecs[12] = '{1'b0, P_ADR,  J_NONE, O_NONE, A_L8,   8'h11, 0, 8'h24, 18'h3AB11, 0};
    vecs[13] = '{1'b0, P_NONE, J_NONE, O_NONE, A_F2,   8'h02, 0, 8'h24, 18'h3AB11, 0};
    vecs[14] = '{1'b0, P_ADR,  J_NONE, O_NONE, A_NONE, 8'h00, 0, 8'h24, 18'h2AB11, 0};

    do_reset("init");

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].pci, vecs[i].prm, vecs[i].code, vecs[i].opr, vecs[i].adr,
           vecs[i].midr, vecs[i].z, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_pc", i),  {24'h0, PC},  {24'h0, vecs[i].exp_pc});
      check($sformatf("vec%0d_dar", i), {14'h0, DAR}, {14'h0, vecs[i].exp_dar});
      check($sformatf("vec%0d_ok", i),  {31'h0, adr_ok}, {31'h0, vecs[i].exp_ok});
    end

    // PC wrap from 0xFF to 0x00.
    step(0, P_JMP, J_JUMP, O_PC, A_NONE, 8'hFF, 0, "wrap_load");
    step(1, P_NONE, J_NONE, O_NONE, A_NONE, 8'h00, 0, "wrap_inc");
    check("wrap_pc", {24'h0, PC}, 32'h0);

    // Reset between mid8 and last8: immediate clear, partial parts discarded.
    step(0, P_ADR, J_NONE, O_NONE, A_F2, 8'h01, 0, "mid_f2");
    step(0, P_NONE, J_NONE, O_NONE, A_F2, 8'h03, 0, "mid_f2b");
    step(1, P_NONE, J_NONE, O_NONE, A_M8, 8'h77, 0, "mid_m8");
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("async_pc",  {24'h0, PC}, 32'h0);
    check("async_dar", {14'h0, DAR}, 32'h0);
    check("async_ok",  {31'h0, adr_ok}, 32'h0);
    model_reset();
    @(negedge clock);
    #1;
    rst = 1'b0;
    step(0, P_NONE, J_NONE, O_NONE, A_L8, 8'h55, 0, "post_l8");
    check("post_ok", {31'h0, adr_ok}, 32'h0);
    step(0, P_ADR, J_NONE, O_NONE, A_NONE, 8'h00, 0, "post_xfer");
    check("post_dar", {14'h0, DAR}, 32'h55);

    // Reset held across an edge carrying a jump: PC stays 0.
    PCI = 1; PRM = P_JMP; PRM_param = J_JUMP; OPR = O_PC; MIDR = 8'h77;
    rst = 1'b1;
    @(negedge clock);
    #1;
    check("rstjmp_pc", {24'h0, PC}, 32'h0);
    idle_inputs();
    model_reset();
    rst = 1'b0;

`ifdef RET_STACK_EN
    step(0, P_JMP, J_JUMP, O_PC, A_NONE, 8'h10, 0, "stk_load");
    step(0, P_JMP, J_CALL, O_PC, A_NONE, 8'h80, 0, "stk_call");
    check("stk_call_pc", {24'h0, PC}, 32'h80);
    step(0, P_JMP, J_RET, O_PC, A_NONE, 8'h00, 0, "stk_ret");
    check("stk_ret_pc", {24'h0, PC}, 32'h11);
    for (int i = 0; i < 5; i++)
      step(0, P_JMP, J_CALL, O_PC, A_NONE, 8'h20 + 8'(i), 0, $sformatf("stk_nest%0d", i));
    check("stk_err_set", {31'h0, stk_err}, 32'h1);
    do_reset("stk");
`else
    step(1, P_JMP, J_CALL, O_PC, A_NONE, 8'h80, 0, "nostk_call");
    check("nostk_call_pc", {24'h0, PC}, 32'h1);
    step(0, P_JMP, J_RET, O_PC, A_NONE, 8'h80, 0, "nostk_ret");
    check("nostk_ret_pc", {24'h0, PC}, 32'h1);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [1:0] r_prm;
      logic [2:0] r_opr;
      r_prm = 2'($urandom_range(0, 3));
      r_opr = ($urandom_range(0, 1) == 1) ? O_PC : 3'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), r_prm, 4'($urandom_range(0, 7)), r_opr,
           4'($urandom_range(0, 5)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
